ex_mem_pipe_fifo: RTL
=====================

// Module: ex_mem_pipe_fifo
// PURPOSE
// Parametrised elastic EX->MEM pipeline stage: successor to the fixed single-register EX/MEM latch.
// Holds up to DEPTH in-flight EX results in a small FIFO with valid/ready handshake on both sides.
// EX can keep issuing while MEM stalls, and a flush squashes all held instructions.
// Bubbles leave with all control enables forced low.
// PARAMETERS
// CTRL_W   3   control bits per entry {MEM_WB_EN, MEM_R_EN, MEM_W_EN}, MSB first
// DATA_W   32  width of ALU result and Rm value fields
// DEST_W   4   destination register index width
// DEPTH    2   FIFO entries; power of two, >= 2
// PORTS
// clk          in   1                clock, rising edge
// rst          in   1                asynchronous, active-low reset
// flush        in   1                synchronous squash of all entries and of this cycle's input beat
// in_valid     in   1                EX presents a beat
// in_ready     out  1                stage accepts a beat this cycle
// in_ctrl      in   CTRL_W           control enables from EX
// in_alu_res   in   DATA_W           ALU result
// in_rm_val    in   DATA_W           Rm store data
// in_dest      in   DEST_W           destination register
// out_valid    out  1                head entry valid
// out_ready    in   1                MEM consumes head this cycle
// out_ctrl     out  CTRL_W           head control; all zero when out_valid=0
// out_alu_res  out  DATA_W           head ALU result
// out_rm_val   out  DATA_W           head Rm value
// out_dest     out  DEST_W           head destination
// count        out  $clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
// - Reset (rst=0, async): storage, rd/wr pointers, and count cleared. out_valid=0, in_ready=1, all out_* = 0.
// - push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
// - in_ready = (count != DEPTH), registered-state only; no combinational path from out_ready.
// - out_valid = (count != 0); out_* driven from entry[rd_ptr] (show-ahead).
// - out_ctrl = out_valid ? entry[rd_ptr].ctrl : 0. Bubbles never assert WB/read/write enables.
// - Latency: a beat pushed at edge N is visible on out_* after edge N; min 1 cycle EX->MEM.
// - Push and pop in the same cycle: both occur, count unchanged. Legal whenever not full.
// - Full: in_ready=0; an in_valid beat is held by EX, never dropped or overwritten.
// - Empty: pop is impossible (out_valid=0); out_ready is ignored.
// - Pointers wrap modulo DEPTH; count saturates by construction between 0 and DEPTH.
// - flush=1 at an edge: count, rd_ptr, wr_ptr -> 0; the current input beat is discarded.
//   Flush beats push/pop. out_valid=0 from the next cycle; storage contents need not be cleared.
// - Async reset mid-operation: all held beats are lost, with no partial state.
// - Data fields pass bit-exact; no arithmetic on payload.
// CONFIGURATION
// EX_MEM_STALL_CNT_EN defined:
// - Adds output stall_cnt [15:0]: increments on each cycle with in_valid=1 & in_ready=0.
// - Saturates at 16'hFFFF.
// - Cleared by reset only; flush does not clear it.
// EX_MEM_STALL_CNT_EN undefined: port and counter are absent. All other behaviour is identical.
// TESTING
// 1 Reset: hold rst=0 with in_valid=1 -> out_valid=0, out_ctrl=0, in_ready=1, count=0; release -> still empty.
// 2 Pass-through: out_ready=1; push {ctrl=3'b101, alu=32'h1234_5678, rm=32'hCAFE_F00D, dest=4'hA}.
//   -> Next cycle identical on out_*; count returns to 0 after the pop.
// 3 Backpressure: out_ready=0; push beats A,B (DEPTH=2) -> count=2, in_ready=0, C held by EX.
//   -> out_ready=1 drains A, B, C in order with no loss or duplication.
// 4 Simultaneous: count=1, push D and pop head in the same cycle -> count stays 1; D next at head.
// 5 Flush: count=2 with flush=1 and in_valid=1 -> next cycle count=0, out_valid=0, out_ctrl=3'b000.
//   -> The flushed-cycle beat never appears at the output.
// 6 With EX_MEM_STALL_CNT_EN: 5 cycles of in_valid=1 while full -> stall_cnt=5; after flush still 5.

Source files
------------

// File: rtl/ex_mem_pipe_fifo_if.sv
// EX->MEM beat bus: EX-side push channel and MEM-side show-ahead head channel.
// master = EX/MEM environment, slave = the pipeline FIFO.
interface ex_mem_pipe_fifo_if #(
   parameter int CTRL_W = 3,
   parameter int DATA_W = 32,
   parameter int DEST_W = 4
);
   // valid/ready: a beat transfers on a rising edge where valid and ready are both 1;
   // the sender keeps valid and payload stable until that edge, ready never depends on valid.
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_alu_res;
   logic [DATA_W-1:0] in_rm_val;
   logic [DEST_W-1:0] in_dest;

   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_alu_res;
   logic [DATA_W-1:0] out_rm_val;
   logic [DEST_W-1:0] out_dest;

   modport master (
      output in_valid, in_ctrl, in_alu_res, in_rm_val, in_dest, out_ready,
      input  in_ready, out_valid, out_ctrl, out_alu_res, out_rm_val, out_dest
   );

   modport slave (
      input  in_valid, in_ctrl, in_alu_res, in_rm_val, in_dest, out_ready,
      output in_ready, out_valid, out_ctrl, out_alu_res, out_rm_val, out_dest
   );
endinterface

// File: rtl/ex_mem_pipe_fifo.sv
// Elastic EX->MEM pipeline stage: DEPTH-entry show-ahead FIFO with flush.
// Optional stall counter output enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_pipe_fifo #(
   parameter int CTRL_W = 3,
   parameter int DATA_W = 32,
   parameter int DEST_W = 4,
   parameter int DEPTH  = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   ex_mem_pipe_fifo_if.slave            bus,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef EX_MEM_STALL_CNT_EN
   ,
   output logic [15:0]                  stall_cnt
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [CTRL_W-1:0] ctrl_q [DEPTH];
   logic [DATA_W-1:0] alu_q  [DEPTH];
   logic [DATA_W-1:0] rm_q   [DEPTH];
   logic [DEST_W-1:0] dest_q [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic full;
   logic empty;
   logic push;
   logic pop;

   // Ready and valid come from registered occupancy only, so MEM stalls never
   // ripple combinationally back into EX.
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.in_valid & ~full & ~flush;
   assign pop   = ~empty & bus.out_ready & ~flush;

   assign bus.in_ready  = ~full;
   assign bus.out_valid = ~empty;
   assign count         = count_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctrl_q[i] <= '0;
            alu_q[i]  <= '0;
            rm_q[i]   <= '0;
            dest_q[i] <= '0;
         end
      end else if (push) begin
         ctrl_q[wr_ptr_q] <= bus.in_ctrl;
         alu_q[wr_ptr_q]  <= bus.in_alu_res;
         rm_q[wr_ptr_q]   <= bus.in_rm_val;
         dest_q[wr_ptr_q] <= bus.in_dest;
      end
   end

   // Bubbles must never carry WB/read/write enables; stale payload is harmless.
   assign bus.out_ctrl    = empty ? '0 : ctrl_q[rd_ptr_q];
   assign bus.out_alu_res = alu_q[rd_ptr_q];
   assign bus.out_rm_val  = rm_q[rd_ptr_q];
   assign bus.out_dest    = dest_q[rd_ptr_q];

`ifdef EX_MEM_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (bus.in_valid && full && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_q <= '0;
      else      stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

endmodule
